// File: rtl/blit_pkg.sv
// Shared types and defaults for the sprite blitter and its offset counter.
package blit_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DRAW = 2'd1,
        DONE = 2'd2
    } blit_state_t;

    localparam int unsigned SCREEN_W_DEF = 160;
    localparam int unsigned SCREEN_H_DEF = 120;
    localparam int unsigned X_W_DEF      = 8;
    localparam int unsigned Y_W_DEF      = 7;
    localparam int unsigned COLOR_W_DEF  = 6;
    localparam int unsigned SPR_DIM_DEF  = 16;

    // Counter width for a dimension of n pixels; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sprite_offset_counter.sv
// Raster-order (cx, cy) offset counter over an SPR_W x SPR_H rectangle.
module sprite_offset_counter
    import blit_pkg::*;
#(
    parameter int unsigned SPR_W = SPR_DIM_DEF,
    parameter int unsigned SPR_H = SPR_DIM_DEF,
    parameter int unsigned CX_W  = cnt_width(SPR_W),
    parameter int unsigned CY_W  = cnt_width(SPR_H)
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            clear,
    input  logic            enable,
    output logic [CX_W-1:0] cx,
    output logic [CY_W-1:0] cy,
    output logic            last
);

    localparam logic [CX_W-1:0] CX_MAX = CX_W'(SPR_W - 1);
    localparam logic [CY_W-1:0] CY_MAX = CY_W'(SPR_H - 1);

    logic cx_wrap;
    logic cy_wrap;

    assign cx_wrap = (cx == CX_MAX);
    assign cy_wrap = (cy == CY_MAX);
    assign last    = cx_wrap && cy_wrap;

    // cx steps every enabled cycle; cy steps when cx wraps.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            cx <= '0;
            cy <= '0;
        end else if (enable) begin
            if (cx_wrap) begin
                cx <= '0;
                cy <= cy_wrap ? '0 : cy + CY_W'(1);
            end else begin
                cx <= cx + CX_W'(1);
            end
        end
    end

endmodule

// File: rtl/sprite_blitter.sv
// Sprite blitter: walks an SPR_W x SPR_H rectangle from a latched origin, one pixel per cycle.
// Define BLIT_CLIP_EN to suppress plot for pixels beyond SCREEN_W/SCREEN_H.
module sprite_blitter
    import blit_pkg::*;
#(
    parameter int unsigned SPR_W    = SPR_DIM_DEF,
    parameter int unsigned SPR_H    = SPR_DIM_DEF,
    parameter int unsigned COLOR_W  = COLOR_W_DEF,
    parameter int unsigned X_W      = X_W_DEF,
    parameter int unsigned Y_W      = Y_W_DEF,
    parameter int unsigned SCREEN_W = SCREEN_W_DEF,
    parameter int unsigned SCREEN_H = SCREEN_H_DEF
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [X_W-1:0]     x0,
    input  logic [Y_W-1:0]     y0,
    input  logic [COLOR_W-1:0] color_in,
    input  logic               undraw,
    output logic               busy,
    output logic               done,
    output logic               plot,
    output logic [X_W-1:0]     x_out,
    output logic [Y_W-1:0]     y_out,
    output logic [COLOR_W-1:0] color_out
);

    localparam int unsigned CX_W = cnt_width(SPR_W);
    localparam int unsigned CY_W = cnt_width(SPR_H);
    localparam int unsigned XS_W = X_W + 1;
    localparam int unsigned YS_W = Y_W + 1;

`ifdef BLIT_CLIP_EN
    localparam bit CLIP_EN = 1'b1;
`else
    localparam bit CLIP_EN = 1'b0;
`endif

    blit_state_t state;
    blit_state_t next_state;

    logic [X_W-1:0]     xl;
    logic [Y_W-1:0]     yl;
    logic [COLOR_W-1:0] color_l;
    logic               undraw_l;

    logic [CX_W-1:0] cx;
    logic [CY_W-1:0] cy;
    logic            last;

    logic latch_en;
    logic cnt_clear;
    logic cnt_en;
    logic pix_en;
    logic busy_d;
    logic done_d;
    logic plot_d;

    logic [XS_W-1:0] x_sum;
    logic [YS_W-1:0] y_sum;
    logic            off_screen;

    sprite_offset_counter #(
        .SPR_W (SPR_W),
        .SPR_H (SPR_H),
        .CX_W  (CX_W),
        .CY_W  (CY_W)
    ) u_offset (
        .clock  (clock),
        .reset  (reset),
        .clear  (cnt_clear),
        .enable (cnt_en),
        .cx     (cx),
        .cy     (cy),
        .last   (last)
    );

    // One extra bit on the sums so the clip compare sees true off-screen overflow.
    assign x_sum      = {1'b0, xl} + XS_W'(cx);
    assign y_sum      = {1'b0, yl} + YS_W'(cy);
    assign off_screen = (x_sum >= XS_W'(SCREEN_W)) || (y_sum >= YS_W'(SCREEN_H));

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // done is still high in the first IDLE cycle, which keeps a start there from being taken.
    always_comb begin
        next_state = state;
        latch_en   = 1'b0;
        cnt_clear  = 1'b0;
        cnt_en     = 1'b0;
        pix_en     = 1'b0;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        plot_d     = 1'b0;
        case (state)
            IDLE: begin
                if (start && !done) begin
                    latch_en   = 1'b1;
                    cnt_clear  = 1'b1;
                    next_state = DRAW;
                end
            end
            DRAW: begin
                cnt_en = 1'b1;
                pix_en = 1'b1;
                busy_d = 1'b1;
                plot_d = !(CLIP_EN && off_screen);
                if (last) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                busy_d     = 1'b1;
                done_d     = 1'b1;
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            xl       <= '0;
            yl       <= '0;
            color_l  <= '0;
            undraw_l <= 1'b0;
        end else if (latch_en) begin
            xl       <= x0;
            yl       <= y0;
            color_l  <= color_in;
            undraw_l <= undraw;
        end
    end

    // Pixel bus is zeroed outside DRAW so idle cycles carry no stale address.
    always_ff @(posedge clock) begin
        if (reset) begin
            busy      <= 1'b0;
            done      <= 1'b0;
            plot      <= 1'b0;
            x_out     <= '0;
            y_out     <= '0;
            color_out <= '0;
        end else begin
            busy <= busy_d;
            done <= done_d;
            plot <= plot_d;
            if (pix_en) begin
                x_out     <= x_sum[X_W-1:0];
                y_out     <= y_sum[Y_W-1:0];
                color_out <= undraw_l ? '0 : color_l;
            end else begin
                x_out     <= '0;
                y_out     <= '0;
                color_out <= '0;
            end
        end
    end

endmodule
